// File: rtl/fp_minmax_seq.sv
// rtl/fp_minmax_seq.sv - streams a DLFloat16 burst through a min/max compare and returns the winner and its index
module fp_minmax_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             mode,
  input  logic             abort,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      res_data,
  output logic [CNT_W-1:0] res_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] best_idx_q, best_idx_d;
  logic             mode_q, mode_d;
  logic [15:0]      best_q, best_d;
  logic             better;

  // Strict "a < b": sign first (-0 below +0), then magnitude, reversed for negatives.
  function automatic logic fp_lt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) begin
      return a[15];
    end else if (a[15]) begin
      return a[14:0] > b[14:0];
    end else begin
      return a[14:0] < b[14:0];
    end
  endfunction

  assign better = mode_q ? fp_lt(best_q, in_data) : fp_lt(in_data, best_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mode_d     = mode_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          // Strict comparison keeps the earliest index on ties.
          if (cnt_q == '0 || better) begin
            best_d     = in_data;
            best_idx_d = cnt_q[CNT_W-1:0];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {1'b0, len_q}) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (abort || res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign in_ready  = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = (state_q == S_DONE) ? best_q : '0;
  assign res_idx   = (state_q == S_DONE) ? best_idx_q : '0;

endmodule

// File: tb/tb_fp_minmax_seq.sv
// tb/tb_fp_minmax_seq.sv - randomized self-checking bench for fp_minmax_seq
module tb_fp_minmax_seq;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             mode;
  logic             abort;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      res_data;
  logic [CNT_W-1:0] res_idx;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  fp_minmax_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] vals [256];

  // Map each encoding to a point on the integer line: negatives below 32768, -0 just under +0.
  function automatic int fp_key(input logic [15:0] v);
    return v[15] ? 32767 - int'(v[14:0]) : 32768 + int'(v[14:0]);
  endfunction

  task automatic ref_win(input bit m, input int n, output logic [15:0] wd, output int wi);
    wd = vals[0];
    wi = 0;
    for (int i = 1; i < n; i++) begin
      if (m ? (fp_key(vals[i]) > fp_key(wd)) : (fp_key(vals[i]) < fp_key(wd))) begin
        wd = vals[i];
        wi = i;
      end
    end
  endtask

  task automatic start_burst(input bit m, input int n);
    len   = CNT_W'(n - 1);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_burst(input bit m, input int n, input bit gaps, input int hold);
    logic [15:0] wd;
    int wi;
    int idx;
    int cyc;
    ref_win(m, n, wd, wi);
    start_burst(m, n);
    check("run_busy", 32'(busy), 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 8 * n + 20) begin
      check("run_in_ready", 32'(in_ready), 32'd1);
      check("run_res_valid", 32'(res_valid), 32'd0);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = vals[idx];
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        len   = CNT_W'($urandom);
        mode  = ~m;
      end
      @(posedge clk); #1;
      if (in_valid) idx++;
      in_valid = 1'b0;
      start    = 1'b0;
      cyc++;
    end
    check("accept_count", 32'(idx), 32'(n));
    check("done_valid", 32'(res_valid), 32'd1);
    check("done_data", 32'(res_data), 32'(wd));
    check("done_idx", 32'(res_idx), 32'(wi));
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len   = CNT_W'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'(wd));
      check("hold_idx", 32'(res_idx), 32'(wi));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("idle_valid", 32'(res_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic feed(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; mode = 1'b0; abort = 1'b0;
    in_data = '0; in_valid = 1'b0; res_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_idx", 32'(res_idx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    vals[0] = 16'h3E00; vals[1] = 16'h4000; vals[2] = 16'hBE00; vals[3] = 16'h3F00;
    run_burst(1'b1, 4, 1'b0, 0);
    run_burst(1'b0, 4, 1'b0, 0);
    vals[0] = 16'h4000; vals[1] = 16'h3E00; vals[2] = 16'h3E00;
    run_burst(1'b0, 3, 1'b0, 0);
    vals[0] = 16'h8000; vals[1] = 16'h0000;
    run_burst(1'b1, 2, 1'b0, 0);
    run_burst(1'b0, 2, 1'b0, 0);
    vals[0] = 16'hC000; vals[1] = 16'hBE00;
    run_burst(1'b1, 2, 1'b0, 0);

    for (int b = 0; b < 12; b++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        if (b % 2 == 0) vals[i] = 16'($urandom);
        else vals[i] = {$urandom_range(0, 1) == 1, 6'h1F, 9'($urandom_range(0, 3))};
      end
      run_burst(b % 3 == 0, n, 1'b1, (b == 0) ? 5 : $urandom_range(0, 3));
    end

    vals[0] = 16'h1234;
    run_burst(1'b0, 1, 1'b0, 0);
    for (int i = 0; i < 256; i++) vals[i] = 16'h3E00;
    run_burst(1'b1, 256, 1'b0, 0);
    for (int i = 0; i < 255; i++) vals[i] = 16'($urandom) & 16'hBFFF;
    vals[255] = 16'h7FFF;
    run_burst(1'b1, 256, 1'b1, 1);

    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'd0);

    start_burst(1'b0, 4);
    feed(16'h1111);
    feed(16'h2222);
    in_valid = 1'b1; in_data = 16'h0001; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("abort_no_result", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
    end
    vals[0] = 16'h0005; vals[1] = 16'h8005; vals[2] = 16'h0007; vals[3] = 16'h0001;
    run_burst(1'b0, 4, 1'b0, 0);

    start_burst(1'b1, 1);
    feed(16'h4444);
    check("done_before_abort", 32'(res_valid), 32'd1);
    abort = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; res_ready = 1'b0;
    check("abort_done_valid", 32'(res_valid), 32'd0);
    check("abort_done_busy", 32'(busy), 32'd0);

    start_burst(1'b1, 4);
    feed(16'h3C00);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_res_data", 32'(res_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    vals[0] = 16'h0200; vals[1] = 16'h0100;
    run_burst(1'b1, 2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
